wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  Registered, parametrised writeback stage of the 5-stage MIPS pipeline; supersedes the 2:1 memtoreg mux.
//  Accepts MEM-stage results over valid/ready and selects one of NUM_SRC result sources.
//  Aligns and sign/zero-extends sub-word loads, then drives the register-file write port one cycle later.
//  Also flags misaligned loads and counts retired instructions.
// PARAMETERS
//  DATA_W   32  datapath width; legal 32 or 64
//  NUM_SRC  4   result sources; src0=ALU, src1=MEM read data, src2=link (PC+8), others user-defined
//  REG_AW   5   register-file address width
//  CNT_W    32  retired-instruction counter width
//  (derived) SEL_W=$clog2(NUM_SRC), AL_W=$clog2(DATA_W/8)
// PORTS
//  clk           in   1              clock, rising edge
//  rst_n         in   1              asynchronous reset, active low
//  flush         in   1              kill held entry and block acceptance this cycle
//  in_valid      in   1              MEM stage presents a result
//  in_ready      out  1              stage can accept
//  in_src        in   NUM_SRC*DATA_W packed sources, src k = [k*DATA_W +: DATA_W]
//  in_sel        in   SEL_W          source select
//  in_ltype      in   3              load type (wb_pkg encoding); used only when in_sel==SRC_MEM
//  in_addr_lo    in   AL_W           load byte offset
//  in_regwrite   in   1              instruction writes a register
//  in_waddr      in   REG_AW         destination register
//  wb_hold       in   1              register-file port busy; hold entry
//  rf_we         out  1              register-file write enable
//  rf_waddr      out  REG_AW         write address (registered)
//  rf_wdata      out  DATA_W         write data (registered)
//  misalign_err  out  1              1-cycle pulse when a misaligned load retires
//  retired_cnt   out  CNT_W          retired-entry count
// BEHAVIOUR
//  - Reset (async, rst_n=0): v_q, rf_waddr, rf_wdata, err_q, misalign_err, retired_cnt all clear to 0; rf_we=0.
//  - in_ready = !flush && (!v_q || !wb_hold). Accept = in_valid && in_ready; loads the stage register, v_q=1.
//  - Retire = v_q && !wb_hold && !flush. Without a same-cycle accept, v_q clears.
//  - Throughput 1/cycle when wb_hold=0. Latency: accept at edge N -> rf_we high in cycle N+1.
//  - rf_we = v_q && we_q && !wb_hold && !flush, where we_q = regwrite && waddr!=0 && !misaligned, captured at accept.
//  - wb_hold: entry, rf_waddr and rf_wdata stay stable and no write occurs. The write happens once, on release.
//  - Priority: rst_n > flush > retire/accept. Flush drops the held entry: no write, no count, no err pulse.
//  - Select: in_sel >= NUM_SRC selects src0.
//  - Load path (sel==SRC_MEM), little-endian, byte k = data[8k+7:8k], lane chosen by in_addr_lo:
//    - LW=0 full 32b, sign-extended to DATA_W. LB=1 and LH=3 sign-extend; LBU=2 and LHU=4 zero-extend.
//    - LD=5 is full width; treated as LW when DATA_W=32. Codes 6/7 behave as LW.
//  - Misaligned: LH/LHU with offset[0]!=0; LW with offset[1:0]!=0; LD with offset!=0.
//    The entry is captured with we_q=0. misalign_err is registered and pulses the cycle after the entry retires.
//  - retired_cnt +1 per retire, including non-writing and misaligned entries. Wraps at 2^CNT_W.
//  - Reset mid-operation discards the held entry; nothing is replayed.
// STRUCTURE
//  - Package wb_pkg holds: LT_LW..LT_LD load encodings, SRC_ALU=0, SRC_MEM=1, SRC_LINK=2.
//  - Sub-module wb_load_align (combinational) takes data, ltype and offset and returns aligned data and misaligned.
//  - Top level holds the source select, stage register, handshake and counter.
// TESTING
//  1 rst_n=0 mid-stream with v_q=1 -> rf_we=0, retired_cnt=0, in_ready=1 immediately.
//  2 sel=0, src0=0x12345678, waddr=5, four back-to-back -> rf_we on 4 consecutive cycles, wdata/waddr match, cnt=4.
//  3 sel=1, mem=0x80817F02:
//    LB off1 -> 0x0000007F; LB off3 -> 0xFFFFFF80; LBU off3 -> 0x00000080;
//    LH off2 -> 0xFFFF8081; LHU off2 -> 0x00008081; LW off0 -> 0x80817F02.
//  4 LH off1, waddr=7 -> rf_we stays 0, misalign_err high exactly 1 cycle, cnt+1.
//  5 wb_hold=1 for 3 cycles with entry held -> in_ready=0, rf_we=0, rf_wdata stable; release -> exactly one write.
//  6 flush with entry held -> no write, cnt unchanged; regwrite=1 with waddr=0 -> rf_we=0, cnt+1.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage.
//   LT_*  : load-type codes presented on in_ltype (only meaningful for SRC_MEM)
//   SRC_* : fixed source slots inside the packed in_src bus
package wb_pkg;

  localparam logic [2:0] LT_LW  = 3'd0;
  localparam logic [2:0] LT_LB  = 3'd1;
  localparam logic [2:0] LT_LBU = 3'd2;
  localparam logic [2:0] LT_LH  = 3'd3;
  localparam logic [2:0] LT_LHU = 3'd4;
  localparam logic [2:0] LT_LD  = 3'd5;

  localparam int SRC_ALU  = 0;
  localparam int SRC_MEM  = 1;
  localparam int SRC_LINK = 2;

endpackage

// File: rtl/wb_load_align.sv
// Combinational load aligner: picks the addressed byte/half/word/dword out of
// little-endian read data and sign/zero-extends it to DATA_W.
// Ports:
//   i_data       raw memory read data
//   i_ltype      load type (wb_pkg LT_* codes; 6/7 behave as LW)
//   i_off        byte offset within the data word
//   o_data       aligned, extended result
//   o_misaligned access is not naturally aligned for its size
module wb_load_align import wb_pkg::*; #(
  parameter  int DATA_W = 32,
  localparam int AL_W   = $clog2(DATA_W/8)
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic [2:0]        i_ltype,
  input  logic [AL_W-1:0]   i_off,
  output logic [DATA_W-1:0] o_data,
  output logic              o_misaligned
);

  logic [DATA_W-1:0] w_sh;

  // Shift the addressed byte down to lane 0; every load type then reads
  // from the bottom of w_sh.
  assign w_sh = i_data >> {i_off, 3'b000};

  always_comb begin
    // LW behaviour is the default (also covers codes 6/7, and LD on 32b).
    o_data       = DATA_W'($signed(w_sh[31:0]));
    o_misaligned = |i_off[1:0];
    case (i_ltype)
      LT_LB: begin
        o_data       = DATA_W'($signed(w_sh[7:0]));
        o_misaligned = 1'b0;
      end
      LT_LBU: begin
        o_data       = DATA_W'(w_sh[7:0]);
        o_misaligned = 1'b0;
      end
      LT_LH: begin
        o_data       = DATA_W'($signed(w_sh[15:0]));
        o_misaligned = i_off[0];
      end
      LT_LHU: begin
        o_data       = DATA_W'(w_sh[15:0]);
        o_misaligned = i_off[0];
      end
      LT_LD: begin
        if (DATA_W > 32) begin
          o_data       = w_sh;
          o_misaligned = |i_off;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Registered writeback stage: selects one of NUM_SRC results, aligns loads,
// holds the result in a one-entry stage register and drives the register-file
// write port the cycle after acceptance.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   flush                  drop held entry, refuse new one this cycle
//   in_valid/in_ready      MEM-stage handshake
//   in_src/in_sel          packed result sources and select (out of range -> src0)
//   in_ltype/in_addr_lo    load type and byte offset (used when in_sel==SRC_MEM)
//   in_regwrite/in_waddr   destination control
//   wb_hold                register-file port busy
//   rf_we/rf_waddr/rf_wdata register-file write port
//   misalign_err           pulse the cycle after a misaligned load retires
//   retired_cnt            retired-entry counter (wraps)
module wb_stage import wb_pkg::*; #(
  parameter  int DATA_W  = 32,
  parameter  int NUM_SRC = 4,
  parameter  int REG_AW  = 5,
  parameter  int CNT_W   = 32,
  localparam int SEL_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int AL_W    = $clog2(DATA_W/8)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_SRC*DATA_W-1:0] in_src,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic [2:0]                in_ltype,
  input  logic [AL_W-1:0]           in_addr_lo,
  input  logic                      in_regwrite,
  input  logic [REG_AW-1:0]         in_waddr,
  input  logic                      wb_hold,
  output logic                      rf_we,
  output logic [REG_AW-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  output logic                      misalign_err,
  output logic [CNT_W-1:0]          retired_cnt
);

  logic              r_v, r_we, r_mis;
  logic [DATA_W-1:0] w_src, w_aligned, w_data;
  logic              w_is_mem, w_al_mis, w_mis;
  logic              w_accept, w_retire;

  // Source select; any select with no matching slot falls back to src0.
  always_comb begin
    w_src = in_src[0 +: DATA_W];
    for (int k = 1; k < NUM_SRC; k++)
      if (int'(in_sel) == k) w_src = in_src[k*DATA_W +: DATA_W];
  end

  wb_load_align #(.DATA_W(DATA_W)) u_align (
    .i_data       (in_src[SRC_MEM*DATA_W +: DATA_W]),
    .i_ltype      (in_ltype),
    .i_off        (in_addr_lo),
    .o_data       (w_aligned),
    .o_misaligned (w_al_mis)
  );

  assign w_is_mem = (int'(in_sel) == SRC_MEM);
  assign w_data   = w_is_mem ? w_aligned : w_src;
  assign w_mis    = w_is_mem && w_al_mis;

  // A held entry may be replaced in the same cycle it retires.
  assign in_ready = !flush && (!r_v || !wb_hold);
  assign w_accept = in_valid && in_ready;
  assign w_retire = r_v && !wb_hold && !flush;
  assign rf_we    = r_v && r_we && !wb_hold && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v          <= 1'b0;
      r_we         <= 1'b0;
      r_mis        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      misalign_err <= 1'b0;
      retired_cnt  <= '0;
    end else begin
      misalign_err <= w_retire && r_mis;
      if (w_retire) retired_cnt <= retired_cnt + CNT_W'(1);
      if (w_accept) begin
        r_v      <= 1'b1;
        // Misaligned loads and r0 writes still occupy the stage and retire,
        // but never reach the register file.
        r_we     <= in_regwrite && (in_waddr != '0) && !w_mis;
        r_mis    <= w_mis;
        rf_waddr <= in_waddr;
        rf_wdata <= w_data;
      end else if (w_retire || flush) begin
        r_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  localparam int DW = 32;
  localparam int NS = 3;   // 3 sources so that in_sel==3 exercises the out-of-range fallback

  logic           clk, rst_n, flush, in_valid, in_ready;
  logic [NS*DW-1:0] in_src;
  logic [1:0]     in_sel;
  logic [2:0]     in_ltype;
  logic [1:0]     in_addr_lo;
  logic           in_regwrite;
  logic [4:0]     in_waddr;
  logic           wb_hold, rf_we, misalign_err;
  logic [4:0]     rf_waddr;
  logic [DW-1:0]  rf_wdata;
  logic [31:0]    retired_cnt;

  wb_stage #(.DATA_W(DW), .NUM_SRC(NS), .REG_AW(5), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_src(in_src), .in_sel(in_sel), .in_ltype(in_ltype), .in_addr_lo(in_addr_lo),
    .in_regwrite(in_regwrite), .in_waddr(in_waddr), .wb_hold(wb_hold),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .misalign_err(misalign_err), .retired_cnt(retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int n_wr = 0, n_pulse = 0;

  // reference model: one held entry plus expected counters
  bit          m_v, m_we, m_mis, m_err;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata, m_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Load result from byte-lane arithmetic.
  function automatic logic [31:0] ld_ref(input logic [31:0] d, input int lt, input int off,
                                         output bit mis);
    logic [31:0] b, h, r;
    b = (d >> (8*off)) & 32'hFF;
    h = (d >> (8*off)) & 32'hFFFF;
    mis = 1'b0;
    case (lt)
      1: r = b[7] ? (b | 32'hFFFF_FF00) : b;
      2: r = b;
      3: begin r = h[15] ? (h | 32'hFFFF_0000) : h; mis = (off % 2) != 0; end
      4: begin r = h; mis = (off % 2) != 0; end
      default: begin r = d; mis = off != 0; end  // LW, LD on 32b, 6/7
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_v = 0; m_we = 0; m_mis = 0; m_err = 0; m_waddr = '0; m_wdata = '0; m_cnt = '0;
  endtask

  // One clock: drive (just after posedge), check mid-cycle, advance model at posedge.
  task automatic cyc(input bit v, input int sel, input logic [31:0] s0, input logic [31:0] s1,
                     input logic [31:0] s2, input int lt, input int off, input bit rw,
                     input int wa, input bit hold, input bit fl);
    bit rdy, acc, ret, mis;
    logic [31:0] d;
    in_valid = v; in_sel = 2'(sel); in_src = {s2, s1, s0}; in_ltype = 3'(lt);
    in_addr_lo = 2'(off); in_regwrite = rw; in_waddr = 5'(wa); wb_hold = hold; flush = fl;
    #2;
    rdy = !fl && (!m_v || !hold);
    chk("in_ready", in_ready, rdy);
    chk("rf_we", rf_we, m_v && m_we && !hold && !fl);
    if (m_v) chk("rf_waddr", rf_waddr, m_waddr);
    if (m_v && m_we) chk("rf_wdata", rf_wdata, m_wdata);
    chk("misalign_err", misalign_err, m_err);
    chk("retired_cnt", retired_cnt, m_cnt);
    if (rf_we) n_wr++;
    if (misalign_err) n_pulse++;
    @(posedge clk);
    acc = v && rdy;
    ret = m_v && !hold && !fl;
    m_err = ret && m_mis;
    if (ret) m_cnt++;
    if (acc) begin
      mis = 1'b0;
      if (sel == 1) d = ld_ref(s1, lt, off, mis);
      else if (sel == 2) d = s2;
      else d = s0;
      m_v = 1; m_mis = mis; m_we = rw && (wa != 0) && !mis;
      m_waddr = 5'(wa); m_wdata = d;
    end else if (ret || fl) m_v = 0;
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  localparam logic [31:0] MEMW = 32'h8081_7F02;
  int          lt_t [6] = '{1, 1, 2, 3, 4, 0};
  int          off_t[6] = '{1, 3, 3, 2, 2, 0};
  logic [31:0] exp_t[6] = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_0080,
                            32'hFFFF_8081, 32'h0000_8081, 32'h8081_7F02};

  initial begin
    int wr0, p0;
    logic [31:0] c0, hold_data;
    rst_n = 0; flush = 0; in_valid = 0; in_src = '0; in_sel = '0; in_ltype = '0;
    in_addr_lo = '0; in_regwrite = 0; in_waddr = '0; wb_hold = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_err", misalign_err, 0);
    chk("rst_cnt", retired_cnt, 0);
    chk("rst_ready", in_ready, 1);
    rst_n = 1;

    // four back-to-back ALU results
    idle();
    wr0 = n_wr; c0 = m_cnt;
    for (int i = 0; i < 4; i++) cyc(1, 0, 32'h1234_5678, 0, 0, 0, 0, 1, 5, 0, 0);
    idle();
    chk("b2b_writes", n_wr - wr0, 4);
    chk("b2b_cnt", retired_cnt - c0, 4);

    // sub-word load extraction against literal results
    for (int i = 0; i < 6; i++) begin
      cyc(1, 1, 32'hDEAD_BEEF, MEMW, 0, lt_t[i], off_t[i], 1, 3, 0, 0);
      chk($sformatf("load%0d", i), rf_wdata, exp_t[i]);
    end
    idle();

    // misaligned LH
    wr0 = n_wr; p0 = n_pulse; c0 = m_cnt;
    cyc(1, 1, 0, MEMW, 0, 3, 1, 1, 7, 0, 0);
    repeat (3) idle();
    chk("mis_writes", n_wr - wr0, 0);
    chk("mis_pulses", n_pulse - p0, 1);
    chk("mis_cnt", retired_cnt - c0, 1);

    // hold for 3 cycles with a pending producer, then release
    wr0 = n_wr;
    cyc(1, 2, 0, 0, 32'hCAFE_0008, 0, 0, 1, 31, 0, 0);
    hold_data = rf_wdata;
    repeat (3) begin
      cyc(1, 0, 32'h5555_AAAA, 0, 0, 0, 0, 1, 9, 1, 0);
      chk("hold_stable", rf_wdata, hold_data);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    chk("hold_one_write", n_wr - wr0, 1);

    // flush drops the held entry; r0 write retires without writing
    wr0 = n_wr; c0 = m_cnt;
    cyc(1, 0, 32'h0BAD_F00D, 0, 0, 0, 0, 1, 4, 0, 0);
    cyc(1, 0, 32'h1111_1111, 0, 0, 0, 0, 1, 6, 0, 1);
    idle();
    chk("flush_writes", n_wr - wr0, 0);
    chk("flush_cnt", retired_cnt - c0, 0);
    cyc(1, 0, 32'h2222_2222, 0, 0, 0, 0, 1, 0, 0, 0);
    idle();
    chk("r0_writes", n_wr - wr0, 0);
    chk("r0_cnt", retired_cnt - c0, 1);

    // sel beyond NUM_SRC falls back to src0
    cyc(1, 3, 32'h3333_0003, 32'h4444_0004, 32'h5555_0005, 0, 0, 1, 2, 0, 0);
    chk("sel_oor", rf_wdata, 32'h3333_0003);
    idle();

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      int wa;
      wa = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 31);
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 3), $urandom, $urandom, $urandom,
          $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 4) != 0, wa,
          $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0);
    end

    // async reset with an entry held
    cyc(1, 0, 32'h7777_7777, 0, 0, 0, 0, 1, 8, 0, 0);
    wb_hold = 1; in_valid = 0;
    rst_n = 0;
    #1;
    chk("rst_mid_we", rf_we, 0);
    chk("rst_mid_cnt", retired_cnt, 0);
    chk("rst_mid_ready", in_ready, 1);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    repeat (3) idle();
    for (int i = 0; i < 40; i++)
      cyc($urandom_range(0, 1), $urandom_range(0, 3), $urandom, $urandom, $urandom,
          $urandom_range(0, 7), $urandom_range(0, 3), 1, $urandom_range(0, 31),
          $urandom_range(0, 3) == 0, 0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
